// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo-MODULUS up/down counter built from JK cells.
// Each count bit is a JK cell (q+ = J&~q | ~K&q) whose J/K inputs encode hold,
// count (toggle), load, reset or modulo-wrap.
// Ports:
//   clk      - clock, rising-edge
//   rst      - synchronous active-high reset
//   en       - count enable
//   up       - direction, 1 = increment, 0 = decrement
//   load     - synchronous parallel load of din (priority over en)
//   din      - load value; values >= MODULUS load 0 and flag load_err
//   count    - current count (registered)
//   tc       - terminal count, combinational from count and up
//   wrap     - registered pulse: count wrapped on the previous edge
//   load_err - registered pulse: an out-of-range load value was replaced by 0
module jk_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH-1:0] j_c, k_c, t_c;
  logic             all_one_c, all_zero_c;
  logic             din_ok_c;

  // Terminal count: the value from which the next step in direction 'up' wraps.
  assign tc = up ? (count_q == MAX_VAL) : (count_q == '0);

  assign din_ok_c = ({1'b0, din} < MOD_EXT);

  // J/K drive per bit and JK next-state evaluation.
  always_comb begin
    j_c        = '0;
    k_c        = '0;
    t_c        = '0;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    all_one_c  = 1'b1;
    all_zero_c = 1'b1;

    // Binary toggle terms: bit i toggles when all lower bits are 1 (up) or 0 (down).
    for (int i = 0; i < WIDTH; i++) begin
      t_c[i]     = en & (up ? all_one_c : all_zero_c);
      all_one_c  = all_one_c & count_q[i];
      all_zero_c = all_zero_c & ~count_q[i];
    end

    if (rst) begin
      j_c = '0;
      k_c = '1;
    end else if (load) begin
      if (din_ok_c) begin
        j_c = din;
        k_c = ~din;
      end else begin
        j_c        = '0;
        k_c        = '1;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (tc) begin
        // Modulo wrap overrides the binary toggle terms.
        wrap_d = 1'b1;
        if (up) begin
          j_c = '0;
          k_c = '1;
        end else begin
          j_c = MAX_VAL;
          k_c = ~MAX_VAL;
        end
      end else begin
        j_c = t_c;
        k_c = t_c;
      end
    end

    count_d = (j_c & ~count_q) | (~k_c & count_q);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed testbench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned MODULUS = 10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  int n_vec;
  int n_err;

  jk_mod_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input int t, input int w, input int le);
    check_eq({tag, ".count"},    32'(count),    32'(c));
    check_eq({tag, ".tc"},       32'(tc),       32'(t));
    check_eq({tag, ".wrap"},     32'(wrap),     32'(w));
    check_eq({tag, ".load_err"}, 32'(load_err), 32'(le));
  endtask

  int up_exp[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_exp[4]   = '{1, 0, 9, 8};
  int dir_exp[4]  = '{5, 4, 5, 4};
  int mid_exp[3]  = '{1, 2, 3};

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset overrides load and en.
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; din = 4'd5;
    #2;
    step();
    step();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 0);
    up = 1'b0;
    #1;
    check_eq("reset.tc_down", 32'(tc), 32'd1);

    // Up count through the wrap.
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_all($sformatf("up%0d", i), up_exp[i], (up_exp[i] == 9) ? 1 : 0, (i == 9) ? 1 : 0, 0);
    end

    // Down count through the wrap.
    en = 1'b0; load = 1'b1; din = 4'd2;
    step();
    check_all("dn_load", 2, 0, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_all($sformatf("dn%0d", i), dn_exp[i], (dn_exp[i] == 0) ? 1 : 0, (i == 2) ? 1 : 0, 0);
    end

    // Load priority over en, illegal loads.
    load = 1'b1; en = 1'b1; up = 1'b1; din = 4'd7;
    step();
    check_all("ld7", 7, 0, 0, 0);
    din = 4'd12;
    step();
    check_all("ld12", 0, 0, 0, 1);
    load = 1'b0; en = 1'b0;
    step();
    check_all("ld12_after", 0, 0, 0, 0);
    load = 1'b1; din = 4'd10;
    step();
    check_all("ld10", 0, 0, 0, 1);
    din = 4'd9;
    step();
    check_all("ld9", 9, 1, 0, 0);
    en = 1'b1;
    step();
    check_all("ld9_tc", 9, 1, 0, 0);

    // Hold, then direction change on every edge.
    din = 4'd4; en = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("hold%0d", i), 4, 0, 0, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      step();
      check_eq($sformatf("dir%0d.count", i), 32'(count), 32'(dir_exp[i]));
      check_eq($sformatf("dir%0d.wrap", i), 32'(wrap), 32'd0);
    end

    // Reset in mid-count.
    en = 1'b0; load = 1'b1; din = 4'd6;
    step();
    check_eq("mid_load", 32'(count), 32'd6);
    load = 1'b0; en = 1'b1; up = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("mid_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("mid%0d", i), mid_exp[i], 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
